// File: rtl/aes_pkg.sv
// Shared definitions for the AES Avalon-MM initiator.
// Slave addresses, bus widths and FSM state types.
package aes_pkg;

    localparam logic [3:0] AES_ADDR_PT   = 4'h0;
    localparam logic [3:0] AES_ADDR_CT   = 4'h4;
    localparam logic [3:0] AES_ADDR_STAT = 4'h8;

    localparam int AES_BLK_W  = 128;
    localparam int AES_WORD_W = 32;

    typedef enum logic {
        W_IDLE,
        W_SEND
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_POLL,
        R_DATA,
        R_OUT
    } rd_state_t;

    // Word 0 is the most significant word of a block.
    function automatic int word_lsb(input logic [1:0] idx);
        return (3 - int'(idx)) * AES_WORD_W;
    endfunction

endpackage

// File: rtl/aes_ct_collector.sv
// Read side: polls slave status, gathers four ciphertext words
// and holds the assembled block until the downstream takes it.
module aes_ct_collector
    import aes_pkg::*;
#(
    parameter int POLL_GAP = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  has_work,
    output logic                  m1_chipselect,
    output logic [3:0]            m1_address,
    output logic                  m1_read,
    input  logic [AES_WORD_W-1:0] m1_readdata,
    input  logic                  m1_waitrequest,
    output logic                  ct_valid,
    input  logic                  ct_ready,
    output logic [AES_BLK_W-1:0]  ct_data,
    output logic                  rd_done
);

    localparam int GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    rd_state_t        r_state;
    rd_state_t        r_next;
    logic [1:0]       rcnt;
    logic [GAP_W-1:0] gap;
    logic             gap_done;
    logic             rd_fire;

    // Current idle cycle is the last one of the gap.
    assign gap_done = (int'(gap) + 1 >= POLL_GAP);
    assign rd_fire  = m1_read & ~m1_waitrequest;

    // Read FSM next state and bus/stream outputs
    always_comb begin
        r_next        = r_state;
        m1_chipselect = 1'b0;
        m1_read       = 1'b0;
        m1_address    = AES_ADDR_PT;
        ct_valid      = 1'b0;
        rd_done       = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (has_work && gap_done) r_next = R_POLL;
            end
            R_POLL: begin
                m1_chipselect = 1'b1;
                m1_read       = 1'b1;
                m1_address    = AES_ADDR_STAT;
                if (!m1_waitrequest) begin
                    if (m1_readdata[0])     r_next = R_DATA;
                    else if (POLL_GAP == 0) r_next = R_POLL;
                    else                    r_next = R_IDLE;
                end
            end
            R_DATA: begin
                m1_chipselect = 1'b1;
                m1_read       = 1'b1;
                m1_address    = AES_ADDR_CT;
                if (!m1_waitrequest && rcnt == 2'd3) begin
                    rd_done = 1'b1;
                    r_next  = R_OUT;
                end
            end
            R_OUT: begin
                ct_valid = 1'b1;
                if (ct_ready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // State, poll gap timer and ciphertext word assembly
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= R_IDLE;
            rcnt    <= '0;
            gap     <= '0;
            ct_data <= '0;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && has_work && !gap_done)
                gap <= gap + 1'b1;
            else
                gap <= '0;
            if (r_state == R_DATA && rd_fire) begin
                ct_data[word_lsb(rcnt) +: AES_WORD_W] <= m1_readdata;
                rcnt <= rcnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/aes_avmm_master.sv
// Avalon-MM initiator for the AES slave: streams plaintext blocks
// into the write port and returns ciphertext blocks in order.
module aes_avmm_master
    import aes_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int POLL_GAP        = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pt_valid,
    output logic                  pt_ready,
    input  logic [AES_BLK_W-1:0]  pt_data,
    output logic                  ct_valid,
    input  logic                  ct_ready,
    output logic [AES_BLK_W-1:0]  ct_data,
    output logic                  m0_chipselect,
    output logic [3:0]            m0_address,
    output logic                  m0_write,
    output logic [AES_WORD_W-1:0] m0_writedata,
    input  logic                  m0_waitrequest,
    output logic                  m1_chipselect,
    output logic [3:0]            m1_address,
    output logic                  m1_read,
    input  logic [AES_WORD_W-1:0] m1_readdata,
    input  logic                  m1_waitrequest
);

    wr_state_t            w_state;
    wr_state_t            w_next;
    logic [1:0]           wcnt;
    logic [AES_BLK_W-1:0] pt_q;
    logic [2:0]           outstanding;
    logic                 wr_done;
    logic                 rd_done;
    logic                 pt_fire;

    assign pt_fire = pt_valid & pt_ready;
    assign wr_done = (w_state == W_SEND) & (wcnt == 2'd3) & ~m0_waitrequest;

    // Write FSM next state and write-port outputs
    always_comb begin
        w_next        = w_state;
        pt_ready      = 1'b0;
        m0_chipselect = 1'b0;
        m0_write      = 1'b0;
        m0_address    = AES_ADDR_PT;
        m0_writedata  = '0;
        unique case (w_state)
            W_IDLE: begin
                pt_ready = !reset && (int'(outstanding) < MAX_OUTSTANDING);
                if (pt_valid && pt_ready) w_next = W_SEND;
            end
            W_SEND: begin
                m0_chipselect = 1'b1;
                m0_write      = 1'b1;
                m0_writedata  = pt_q[word_lsb(wcnt) +: AES_WORD_W];
                if (wr_done) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write state, word counter, block latch and in-flight count
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state     <= W_IDLE;
            wcnt        <= '0;
            pt_q        <= '0;
            outstanding <= '0;
        end else begin
            w_state <= w_next;
            if (pt_fire) begin
                pt_q <= pt_data;
                wcnt <= '0;
            end else if (w_state == W_SEND && !m0_waitrequest) begin
                wcnt <= wcnt + 2'd1;
            end
            if (wr_done && !rd_done)
                outstanding <= outstanding + 3'd1;
            else if (rd_done && !wr_done)
                outstanding <= outstanding - 3'd1;
        end
    end

    aes_ct_collector #(
        .POLL_GAP(POLL_GAP)
    ) u_collector (
        .clock         (clock),
        .reset         (reset),
        .has_work      (outstanding != 3'd0),
        .m1_chipselect (m1_chipselect),
        .m1_address    (m1_address),
        .m1_read       (m1_read),
        .m1_readdata   (m1_readdata),
        .m1_waitrequest(m1_waitrequest),
        .ct_valid      (ct_valid),
        .ct_ready      (ct_ready),
        .ct_data       (ct_data),
        .rd_done       (rd_done)
    );

endmodule

// File: tb/tb_aes_avmm_master.sv
// Bench for aes_avmm_master with a loopback AES slave model
// (ciphertext = plaintext ^ all-ones, programmable FIFO latency).
module tb_aes_avmm_master;
    import aes_pkg::*;

    localparam int MAXO = 2;
    localparam int GAP  = 4;
    localparam logic [127:0] ONES = '1;
    localparam logic [127:0] PT1  = 128'h00112233_44556677_8899aabb_ccddeeff;

    logic         clock    = 1'b0;
    logic         reset    = 1'b1;
    logic         pt_valid = 1'b0;
    logic         pt_ready;
    logic [127:0] pt_data  = '0;
    logic         ct_valid;
    logic         ct_ready = 1'b0;
    logic [127:0] ct_data;
    logic         m0_chipselect;
    logic [3:0]   m0_address;
    logic         m0_write;
    logic [31:0]  m0_writedata;
    logic         m0_waitrequest;
    logic         m1_chipselect;
    logic [3:0]   m1_address;
    logic         m1_read;
    logic [31:0]  m1_readdata;
    logic         m1_waitrequest;

    aes_avmm_master #(
        .MAX_OUTSTANDING(MAXO),
        .POLL_GAP       (GAP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pt_valid      (pt_valid),
        .pt_ready      (pt_ready),
        .pt_data       (pt_data),
        .ct_valid      (ct_valid),
        .ct_ready      (ct_ready),
        .ct_data       (ct_data),
        .m0_chipselect (m0_chipselect),
        .m0_address    (m0_address),
        .m0_write      (m0_write),
        .m0_writedata  (m0_writedata),
        .m0_waitrequest(m0_waitrequest),
        .m1_chipselect (m1_chipselect),
        .m1_address    (m1_address),
        .m1_read       (m1_read),
        .m1_readdata   (m1_readdata),
        .m1_waitrequest(m1_waitrequest)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    logic         force_m0 = 1'b0;
    logic         rnd_m0   = 1'b0;
    logic         m0_rand  = 1'b0;
    logic         stat0    = 1'b0;
    int           ct_mode  = 0;
    int           lat      = 2;
    logic [31:0]  wbuf [3];
    int           wi = 0, ri = 0, cyc = 0, n_wr = 0, n_rd = 0;
    logic [127:0] pendq[$];
    logic [127:0] rdyq[$];
    int           dueq[$];
    logic         avail = 1'b0;
    logic [127:0] head  = '0;

    assign m0_waitrequest = force_m0 | rnd_m0;
    assign m1_waitrequest = m1_read && (m1_address == AES_ADDR_CT) && !avail;

    always_comb begin
        m1_readdata = '0;
        if (m1_address == AES_ADDR_STAT)
            m1_readdata = {31'b0, avail & ~stat0};
        else if (m1_address == AES_ADDR_CT)
            m1_readdata = head[(3 - ri) * 32 +: 32];
    end

    always @(posedge clock) begin
        if (reset) begin
            wi <= 0; ri <= 0; n_wr <= 0; n_rd <= 0;
            pendq.delete(); rdyq.delete(); dueq.delete();
            avail <= 1'b0; head <= '0;
        end else begin
            cyc <= cyc + 1;
            if (m0_write && !m0_waitrequest) begin
                if (wi == 3) begin
                    pendq.push_back({wbuf[0], wbuf[1], wbuf[2], m0_writedata} ^ ONES);
                    dueq.push_back(cyc + lat);
                    n_wr <= n_wr + 1;
                    wi <= 0;
                end else begin
                    wbuf[wi] <= m0_writedata;
                    wi <= wi + 1;
                end
            end
            if (m1_read && m1_address == AES_ADDR_CT && !m1_waitrequest) begin
                if (ri == 3) begin
                    void'(rdyq.pop_front());
                    n_rd <= n_rd + 1;
                    ri <= 0;
                end else begin
                    ri <= ri + 1;
                end
            end
            if (dueq.size() != 0 && dueq[0] <= cyc) begin
                rdyq.push_back(pendq.pop_front());
                void'(dueq.pop_front());
            end
            avail <= (rdyq.size() != 0);
            head  <= (rdyq.size() != 0) ? rdyq[0] : '0;
        end
    end

    // ---------------- input drivers ----------------
    initial forever begin
        @(posedge clock);
        #1;
        ct_ready = (ct_mode == 0) || (ct_mode == 2 && $urandom_range(0, 1) == 1);
        rnd_m0   = m0_rand && ($urandom_range(0, 3) == 0);
    end

    // ---------------- monitor / scoreboard ----------------
    logic [127:0] expq[$];
    logic [127:0] last_ct = '0;
    int           n_ct = 0;
    int           ncyc = 0;
    int           pollq[$];
    int           ct_reads = 0;
    logic         p_m0_write = 0, p_m0_wait = 0, p_ct_valid = 0, p_ct_ready = 0;
    logic [31:0]  p_m0_wd = '0;
    logic [127:0] p_ct = '0;

    initial forever begin
        @(negedge clock);
        ncyc++;
        if (reset) begin
            expq.delete();
            p_m0_write = 0; p_m0_wait = 0; p_ct_valid = 0; p_ct_ready = 0;
        end else begin
            if (pt_valid && pt_ready) expq.push_back(pt_data ^ ONES);
            if (ct_valid && ct_ready) begin
                last_ct = ct_data;
                n_ct++;
                if (expq.size() == 0) chk("ct_unexpected", 128'(expq.size()), 128'd1);
                else                  chk("ct_order", ct_data, expq.pop_front());
            end
            if (p_m0_write && p_m0_wait)
                chk("m0_stable", 128'({m0_write, m0_writedata}), 128'({1'b1, p_m0_wd}));
            if (p_ct_valid && !p_ct_ready) begin
                chk("ct_valid_hold", 128'(ct_valid), 128'd1);
                chk("ct_data_hold", ct_data, p_ct);
            end
            chk("m0_cs", 128'(m0_chipselect), 128'(m0_write));
            chk("m1_cs", 128'(m1_chipselect), 128'(m1_read));
            chk("m0_addr", 128'(m0_address), 128'd0);
            chk("m1_addr", 128'(m1_read ? (m1_address == AES_ADDR_STAT || m1_address == AES_ADDR_CT)
                                         : (m1_address == 4'h0)), 128'd1);
            chk("outst_range", 128'(n_wr >= n_rd && n_wr - n_rd <= MAXO), 128'd1);
            if (pt_ready) chk("pt_ready_limit", 128'(n_wr - n_rd < MAXO), 128'd1);
            if (stat0 && m1_read && m1_address == AES_ADDR_STAT) pollq.push_back(ncyc);
            if (stat0 && m1_read && m1_address == AES_ADDR_CT) ct_reads++;
            p_m0_write = m0_write; p_m0_wait = m0_waitrequest; p_m0_wd = m0_writedata;
            p_ct_valid = ct_valid; p_ct_ready = ct_ready; p_ct = ct_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- tasks ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [127:0] d);
        int t = 0;
        pt_valid = 1'b1;
        pt_data  = d;
        do begin
            @(negedge clock);
            t++;
        end while (!pt_ready && t < 500);
        if (!pt_ready) chk("pt_timeout", 128'(pt_ready), 128'd1);
        @(posedge clock);
        #1;
        pt_valid = 1'b0;
    endtask

    task automatic wait_ct(input int target);
        int t = 0;
        while (n_ct < target && t < 3000) begin
            @(negedge clock);
            t++;
        end
        if (n_ct < target) chk("ct_timeout", 128'(n_ct), 128'(target));
        @(posedge clock);
        #1;
    endtask

    task automatic wait_word(input logic [31:0] w, output bit ok);
        int t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!(m0_write && m0_writedata == w) && t < 200);
        ok = m0_write && (m0_writedata == w);
        if (!ok) chk("word_timeout", 128'(m0_writedata), 128'(w));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit           ok;
        int           base;
        int           rd0;
        logic [127:0] b0, b1, b2, bb;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ctrl", 128'({pt_ready, ct_valid, m0_chipselect, m0_write, m0_address,
                              m1_chipselect, m1_read, m1_address}), 128'd0);
        chk("rst_ct_data", ct_data, 128'd0);
        chk("rst_wdata", 128'(m0_writedata), 128'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // directed block, no stalls: four consecutive words
        send(PT1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("t1_word", 128'({m0_write, m0_writedata}),
                128'({1'b1, PT1[(3 - i) * 32 +: 32]}));
        end
        wait_ct(1);
        chk("t1_ct", last_ct, 128'hffeeddcc_bbaa9988_77665544_33221100);

        // stall on the last word for three cycles
        send(PT1);
        wait_word(32'hccddeeff, ok);
        if (ok) begin
            #1 force_m0 = 1'b1;
            @(negedge clock);
            chk("t2_hold", 128'({m0_write, m0_writedata}), 128'({1'b1, 32'hccddeeff}));
            @(negedge clock);
            chk("t2_hold", 128'({m0_write, m0_writedata}), 128'({1'b1, 32'hccddeeff}));
            @(posedge clock);
            #1 force_m0 = 1'b0;
            @(negedge clock);
            chk("t2_hold", 128'({m0_write, m0_writedata}), 128'({1'b1, 32'hccddeeff}));
        end
        wait_ct(2);
        chk("t2_ct", last_ct, PT1 ^ ONES);
        chk("t2_blocks", 128'(n_wr), 128'd2);

        // status stuck at 0: polls spaced GAP+1 cycles, no data reads
        pollq.delete();
        ct_reads = 0;
        stat0 = 1'b1;
        send(rnd128());
        repeat (40) @(negedge clock);
        @(posedge clock);
        #1 stat0 = 1'b0;
        chk("t3_no_ct_read", 128'(ct_reads), 128'd0);
        chk("t3_poll_count", 128'(pollq.size() >= 5), 128'd1);
        for (int i = 1; i < pollq.size(); i++)
            chk("t3_poll_gap", 128'(pollq[i] - pollq[i - 1]), 128'(GAP + 1));
        wait_ct(3);

        // back-pressure: limit of two blocks in flight
        base = n_ct;
        lat = 30;
        ct_mode = 1;
        b0 = rnd128(); b1 = rnd128(); b2 = rnd128();
        @(posedge clock);
        #1;
        send(b0);
        send(b1);
        repeat (5) @(negedge clock);
        chk("t4_full_ready", 128'(pt_ready), 128'd0);
        chk("t4_full_count", 128'(n_wr - n_rd), 128'd2);
        rd0 = n_rd;
        @(posedge clock);
        #1;
        send(b2);
        chk("t4_third_after_read", 128'(n_rd - rd0 >= 1), 128'd1);
        chk("t4_no_ct_yet", 128'(n_ct), 128'(base));
        ct_mode = 2;
        lat = 2;
        wait_ct(base + 3);

        // reset in the middle of traffic
        lat = 0;
        bb = 128'h01010101_02020202_03030303_04040404;
        send(rnd128());
        send(bb);
        wait_word(32'h03030303, ok);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("t6_rst_ctrl", 128'({pt_ready, ct_valid, m0_chipselect, m0_write, m0_address,
                                 m1_chipselect, m1_read, m1_address}), 128'd0);
        chk("t6_rst_ct", ct_data, 128'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        base = n_ct;
        bb = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        send(bb);
        wait_ct(base + 1);
        chk("t6_ct", last_ct, bb ^ ONES);

        // random traffic with random stalls and latencies
        base = n_ct;
        m0_rand = 1'b1;
        for (int i = 0; i < 25; i++) begin
            lat = $urandom_range(0, 6);
            send(rnd128());
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 6)) @(posedge clock);
            #1;
        end
        wait_ct(base + 25);
        m0_rand = 1'b0;
        ct_mode = 0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        chk("drain_balance", 128'(n_wr - n_rd), 128'd0);
        chk("drain_ready", 128'(pt_ready), 128'd1);
        chk("drain_scoreboard", 128'(expq.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
